// File: rtl/diff_commit_stage.sv
`default_nettype none
// ============================================================================
// Module   : diff_commit_stage
// Purpose  : Registered writeback-to-difftest staging with counters, halt
//            latch and an optional commit watchdog (DIFF_COMMIT_WATCHDOG_EN).
// Revision : 1.0
// ============================================================================
module diff_commit_stage #(
   parameter int TIMEOUT_CYCLES = 5000,
   parameter int CNT_W          = 64
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [63:0]      in_pc,
   input  logic [31:0]      in_instr,
   input  logic             in_skip,
   input  logic             in_wen,
   input  logic [7:0]       in_wdest,
   input  logic [63:0]      in_wdata,
   input  logic             in_csrRstat,
   input  logic [63:0]      in_csrData,
   input  logic             in_storeEn,
   input  logic             in_loadEn,
   input  logic [63:0]      in_storePaddr,
   input  logic [63:0]      in_storeVaddr,
   input  logic [63:0]      in_storeData,
   input  logic [63:0]      in_loadPaddr,
   input  logic [63:0]      in_loadVaddr,
   input  logic [63:0]      in_loadData,
   input  logic [7:0]       in_memLen,
   input  logic             in_excpValid,
   input  logic             in_isMret,
   input  logic [31:0]      in_intrptNo,
   input  logic [31:0]      in_cause,
   input  logic             in_halt,
   output logic             o_instrValid,
   output logic [7:0]       o_index,
   output logic [63:0]      o_pc,
   output logic [31:0]      o_instr,
   output logic             o_skip,
   output logic             o_wen,
   output logic [7:0]       o_wdest,
   output logic [63:0]      o_wdata,
   output logic             o_csrRstat,
   output logic [63:0]      o_csrData,
   output logic [7:0]       o_storeIndex,
   output logic [7:0]       o_storeValid,
   output logic [63:0]      o_storePaddr,
   output logic [63:0]      o_storeVaddr,
   output logic [63:0]      o_storeData,
   output logic [7:0]       o_storeLen,
   output logic [7:0]       o_loadIndex,
   output logic [7:0]       o_loadValid,
   output logic [63:0]      o_loadPaddr,
   output logic [63:0]      o_loadVaddr,
   output logic [63:0]      o_loadData,
   output logic [7:0]       o_loadLen,
   output logic             o_excpValid,
   output logic             o_isMret,
   output logic [31:0]      o_intrptNo,
   output logic [31:0]      o_cause,
   output logic [63:0]      o_exceptionPC,
   output logic [31:0]      o_exceptionInst,
   output logic [CNT_W-1:0] o_instrCnt,
   output logic [CNT_W-1:0] o_cycleCnt,
   output logic             o_halted,
   output logic             o_timeout
);

   typedef enum logic [1:0] {
      S_RUN     = 2'd0,
      S_HALTED  = 2'd1,
      S_TIMEOUT = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic             instr_valid_q, instr_valid_d, excp_valid_q, excp_valid_d;
   logic             is_mret_q, is_mret_d, skip_q, skip_d, wen_q, wen_d;
   logic             csr_rstat_q, csr_rstat_d;
   logic [63:0]      pc_q, pc_d, wdata_q, wdata_d, csr_data_q, csr_data_d;
   logic [31:0]      instr_q, instr_d, intrpt_no_q, intrpt_no_d, cause_q, cause_d;
   logic [7:0]       wdest_q, wdest_d;
   logic [63:0]      exc_pc_q, exc_pc_d;
   logic [31:0]      exc_inst_q, exc_inst_d;
   logic [7:0]       store_valid_q, store_valid_d, store_len_q, store_len_d;
   logic [63:0]      store_paddr_q, store_paddr_d, store_vaddr_q, store_vaddr_d;
   logic [63:0]      store_data_q, store_data_d;
   logic [7:0]       load_valid_q, load_valid_d, load_len_q, load_len_d;
   logic [63:0]      load_paddr_q, load_paddr_d, load_vaddr_q, load_vaddr_d;
   logic [63:0]      load_data_q, load_data_d;
   logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d, cycle_cnt_q, cycle_cnt_d;

   logic w_commit, w_trap;

`ifdef DIFF_COMMIT_WATCHDOG_EN
   localparam int IDLE_W = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT_CYCLES - 1);
   logic [IDLE_W-1:0] idle_q, idle_d;
`endif

   assign w_commit = in_valid & ~in_excpValid;
   assign w_trap   = in_valid &  in_excpValid;

   // Unsupported lengths yield an empty mask; the shift truncates to the 8-byte beat.
   function automatic logic [7:0] byte_mask(input logic [7:0] len, input logic [2:0] off);
      logic [7:0] size_mask;
      case (len)
         8'd1:    size_mask = 8'h01;
         8'd2:    size_mask = 8'h03;
         8'd4:    size_mask = 8'h0F;
         8'd8:    size_mask = 8'hFF;
         default: size_mask = 8'h00;
      endcase
      return size_mask << off;
   endfunction

   always_comb begin
      state_d       = state_q;
      instr_valid_d = 1'b0;
      excp_valid_d  = 1'b0;
      is_mret_d     = 1'b0;
      store_valid_d = 8'h00;
      load_valid_d  = 8'h00;
      pc_d          = pc_q;        instr_d       = instr_q;
      skip_d        = skip_q;      wen_d         = wen_q;
      wdest_d       = wdest_q;     wdata_d       = wdata_q;
      csr_rstat_d   = csr_rstat_q; csr_data_d    = csr_data_q;
      intrpt_no_d   = intrpt_no_q; cause_d       = cause_q;
      exc_pc_d      = exc_pc_q;    exc_inst_d    = exc_inst_q;
      store_paddr_d = store_paddr_q; store_vaddr_d = store_vaddr_q;
      store_data_d  = store_data_q;  store_len_d   = store_len_q;
      load_paddr_d  = load_paddr_q;  load_vaddr_d  = load_vaddr_q;
      load_data_d   = load_data_q;   load_len_d    = load_len_q;
      instr_cnt_d   = instr_cnt_q;
      cycle_cnt_d   = cycle_cnt_q;
`ifdef DIFF_COMMIT_WATCHDOG_EN
      idle_d        = idle_q;
`endif
      if (state_q == S_RUN) begin
         cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
         if (w_commit) begin
            instr_valid_d = 1'b1;
            is_mret_d     = in_isMret;
            pc_d          = in_pc;       instr_d     = in_instr;
            skip_d        = in_skip;     wen_d       = in_wen;
            wdest_d       = in_wdest;    wdata_d     = in_wdata;
            csr_rstat_d   = in_csrRstat; csr_data_d  = in_csrData;
            instr_cnt_d   = instr_cnt_q + CNT_W'(1);
            if (in_halt) state_d = S_HALTED;
            if (in_storeEn) begin
               store_valid_d = byte_mask(in_memLen, in_storePaddr[2:0]);
               store_paddr_d = in_storePaddr; store_vaddr_d = in_storeVaddr;
               store_data_d  = in_storeData;  store_len_d   = in_memLen;
            end
            if (in_loadEn) begin
               load_valid_d = byte_mask(in_memLen, in_loadPaddr[2:0]);
               load_paddr_d = in_loadPaddr; load_vaddr_d = in_loadVaddr;
               load_data_d  = in_loadData;  load_len_d   = in_memLen;
            end
         end
         if (w_trap) begin
            excp_valid_d = 1'b1;
            exc_pc_d     = in_pc;       exc_inst_d = in_instr;
            intrpt_no_d  = in_intrptNo; cause_d    = in_cause;
         end
`ifdef DIFF_COMMIT_WATCHDOG_EN
         // Any retirement (commit or trap) proves forward progress.
         if (in_valid)                  idle_d  = '0;
         else if (idle_q == IDLE_LIMIT) state_d = S_TIMEOUT;
         else                           idle_d  = idle_q + IDLE_W'(1);
`endif
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= S_RUN;
         instr_valid_q <= 1'b0;  excp_valid_q  <= 1'b0;  is_mret_q   <= 1'b0;
         store_valid_q <= 8'h00; load_valid_q  <= 8'h00;
         pc_q          <= '0;    instr_q       <= '0;    skip_q      <= 1'b0;
         wen_q         <= 1'b0;  wdest_q       <= '0;    wdata_q     <= '0;
         csr_rstat_q   <= 1'b0;  csr_data_q    <= '0;
         intrpt_no_q   <= '0;    cause_q       <= '0;
         exc_pc_q      <= '0;    exc_inst_q    <= '0;
         store_paddr_q <= '0;    store_vaddr_q <= '0;
         store_data_q  <= '0;    store_len_q   <= '0;
         load_paddr_q  <= '0;    load_vaddr_q  <= '0;
         load_data_q   <= '0;    load_len_q    <= '0;
         instr_cnt_q   <= '0;    cycle_cnt_q   <= '0;
      end else begin
         state_q       <= state_d;
         instr_valid_q <= instr_valid_d; excp_valid_q  <= excp_valid_d;
         is_mret_q     <= is_mret_d;
         store_valid_q <= store_valid_d; load_valid_q  <= load_valid_d;
         pc_q          <= pc_d;          instr_q       <= instr_d;
         skip_q        <= skip_d;        wen_q         <= wen_d;
         wdest_q       <= wdest_d;       wdata_q       <= wdata_d;
         csr_rstat_q   <= csr_rstat_d;   csr_data_q    <= csr_data_d;
         intrpt_no_q   <= intrpt_no_d;   cause_q       <= cause_d;
         exc_pc_q      <= exc_pc_d;      exc_inst_q    <= exc_inst_d;
         store_paddr_q <= store_paddr_d; store_vaddr_q <= store_vaddr_d;
         store_data_q  <= store_data_d;  store_len_q   <= store_len_d;
         load_paddr_q  <= load_paddr_d;  load_vaddr_q  <= load_vaddr_d;
         load_data_q   <= load_data_d;   load_len_q    <= load_len_d;
         instr_cnt_q   <= instr_cnt_d;   cycle_cnt_q   <= cycle_cnt_d;
      end
   end

`ifdef DIFF_COMMIT_WATCHDOG_EN
   always_ff @(posedge clock) begin
      if (reset) idle_q <= '0;
      else       idle_q <= idle_d;
   end
`endif

   assign o_instrValid    = instr_valid_q;
   assign o_index         = 8'd0;
   assign o_pc            = pc_q;
   assign o_instr         = instr_q;
   assign o_skip          = skip_q;
   assign o_wen           = wen_q;
   assign o_wdest         = wdest_q;
   assign o_wdata         = wdata_q;
   assign o_csrRstat      = csr_rstat_q;
   assign o_csrData       = csr_data_q;
   assign o_storeIndex    = 8'd0;
   assign o_storeValid    = store_valid_q;
   assign o_storePaddr    = store_paddr_q;
   assign o_storeVaddr    = store_vaddr_q;
   assign o_storeData     = store_data_q;
   assign o_storeLen      = store_len_q;
   assign o_loadIndex     = 8'd0;
   assign o_loadValid     = load_valid_q;
   assign o_loadPaddr     = load_paddr_q;
   assign o_loadVaddr     = load_vaddr_q;
   assign o_loadData      = load_data_q;
   assign o_loadLen       = load_len_q;
   assign o_excpValid     = excp_valid_q;
   assign o_isMret        = is_mret_q;
   assign o_intrptNo      = intrpt_no_q;
   assign o_cause         = cause_q;
   assign o_exceptionPC   = exc_pc_q;
   assign o_exceptionInst = exc_inst_q;
   assign o_instrCnt      = instr_cnt_q;
   assign o_cycleCnt      = cycle_cnt_q;
   assign o_halted        = (state_q == S_HALTED);
   // Without the watchdog S_TIMEOUT is never entered, so this reads constant 0.
   assign o_timeout       = (state_q == S_TIMEOUT);

endmodule
`default_nettype wire
